// File: rtl/vector_sum_pkg.sv
// Shared types and width helpers for the vector-sum sequencer.
//   state_e     - sequencer FSM states
//   clog2       - ceiling log2, usable in parameter expressions
//   calc_w_s    - scalar result width for a DIM-element sum of W_u-bit values
//   calc_w_r    - row tag width, never narrower than 1 bit
package vector_sum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int calc_w_s(input int w_u, input int dim);
    return w_u + clog2(dim);
  endfunction

  function automatic int calc_w_r(input int rows);
    return (clog2(rows) > 1) ? clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/vector_sum_sequencer_if.sv
// Operand and result streams of the vector-sum sequencer.
//   vec_valid/vec_ready/vec_data        - input vector stream
//   res_valid/res_ready/res_data/res_row/res_last - scalar result stream
// master: upstream fetch + downstream write-back side; slave: the sequencer.
interface vector_sum_sequencer_if
  import vector_sum_pkg::*;
#(
  parameter int DIM = 10,
  parameter int W_u = 32,
  parameter int W_S = calc_w_s(W_u, DIM),
  parameter int W_R = 2
);

  logic               vec_valid;
  logic               vec_ready;
  logic [DIM*W_u-1:0] vec_data;

  logic               res_valid;
  logic               res_ready;
  logic [W_S-1:0]     res_data;
  logic [W_R-1:0]     res_row;
  logic               res_last;

  modport master (
    output vec_valid, vec_data, res_ready,
    input  vec_ready, res_valid, res_data, res_row, res_last
  );

  modport slave (
    input  vec_valid, vec_data, res_ready,
    output vec_ready, res_valid, res_data, res_row, res_last
  );

endinterface

// File: rtl/vector_sum_sequencer_fifo.sv
// Synchronous FIFO holding tagged results until downstream accepts them.
//   i_clk, i_rst       - clock, synchronous active-high reset
//   i_push, i_wr_data  - write side
//   i_pop, o_rd_data   - read side; o_rd_data is the head, zero when empty
//   o_count, o_empty, o_full - occupancy
// A push while full is accepted only when the head is popped in the same cycle.
module sync_fifo
  import vector_sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vector_sum_sequencer.sv
// Shares one pipelined vectorSum datapath among the ROWS vectors of a job.
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_start       - begin a job (IDLE only)
//   o_busy        - job in RUN or DRAIN
//   o_done        - one-cycle pulse after the last result is handed off
//   o_sum_u       - registered vector to the datapath
//   i_sum_in      - datapath sum, LAT cycles after o_sum_u
//   s_if          - vector input stream and tagged result stream
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for i_start
// ST_RUN   | issuing rows into the datapath
// ST_DRAIN | all rows issued, waiting for last result handoff
// ST_DONE  | single-cycle done pulse
module vector_sum_sequencer
  import vector_sum_pkg::*;
#(
  parameter int DIM   = 10,
  parameter int W_u   = 32,
  parameter int ROWS  = 4,
  parameter int LAT   = 4,
  parameter int DEPTH = LAT + 2,
  localparam int W_S  = calc_w_s(W_u, DIM),
  localparam int W_R  = calc_w_r(ROWS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [DIM*W_u-1:0] o_sum_u,
  input  logic [W_S-1:0]     i_sum_in,
  vector_sum_sequencer_if.slave s_if
);

  localparam int CNTW = W_R + 1;
  localparam int FW   = W_S + W_R + 1;
  localparam int FCW  = clog2(DEPTH + 1);
  localparam int CW   = clog2(DEPTH + LAT + 2);

  state_e             r_state;
  state_e             w_next;
  logic [CNTW-1:0]    r_issue_cnt;
  logic [CNTW-1:0]    r_retire_cnt;
  logic [DIM*W_u-1:0] r_sum_u;
  // Stage 0 is aligned with r_sum_u; stage LAT lines up with i_sum_in.
  logic [LAT:0]       r_vld;
  logic [W_R-1:0]     r_tag [LAT+1];

  logic               w_start;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_credit;
  logic [CW-1:0]      w_inflight;
  logic [CW-1:0]      w_outstanding;
  logic [FCW-1:0]     w_fifo_count;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [FW-1:0]      w_fifo_in;
  logic [FW-1:0]      w_fifo_head;

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k <= LAT; k++) w_inflight = w_inflight + CW'(r_vld[k]);
  end

  // Every issued-but-unpopped row already owns a FIFO slot, so a push never
  // meets a full FIFO unless the same cycle pops.
  assign w_outstanding  = w_inflight + CW'(w_fifo_count);
  assign w_credit       = (w_outstanding < CW'(DEPTH));
  assign s_if.vec_ready = (r_state == ST_RUN) && w_credit;
  assign w_issue        = s_if.vec_valid && s_if.vec_ready;
  assign w_start        = (r_state == ST_IDLE) && i_start;

  assign w_push    = r_vld[LAT];
  assign w_fifo_in = {i_sum_in, r_tag[LAT], (r_tag[LAT] == W_R'(ROWS - 1))};

  assign s_if.res_valid = !w_fifo_empty;
  assign w_pop          = s_if.res_valid && s_if.res_ready;
  assign {s_if.res_data, s_if.res_row, s_if.res_last} = w_fifo_head;
  assign o_sum_u        = r_sum_u;

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (w_issue && (r_issue_cnt == CNTW'(ROWS - 1))) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (w_pop && (r_retire_cnt == CNTW'(ROWS - 1))) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_issue_cnt  <= '0;
      r_retire_cnt <= '0;
      r_sum_u      <= '0;
      r_vld        <= '0;
      for (int k = 0; k <= LAT; k++) r_tag[k] <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_issue_cnt  <= '0;
        r_retire_cnt <= '0;
        r_vld        <= '0;
      end else begin
        if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
        if (w_pop)   r_retire_cnt <= r_retire_cnt + 1'b1;
        r_vld <= {r_vld[LAT-1:0], w_issue};
      end
      if (w_issue) r_sum_u <= s_if.vec_data;
      r_tag[0] <= r_issue_cnt[W_R-1:0];
      for (int k = 1; k <= LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  a_push_not_full: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && w_fifo_full && !w_pop));

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (w_push),
    .i_wr_data (w_fifo_in),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_head),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

endmodule

// File: tb/tb_vector_sum_sequencer.sv
module tb_vector_sum_sequencer;
  import vector_sum_pkg::*;

  localparam int DIM = 10;
  localparam int W_u = 32;
  localparam int LAT = 4;
  localparam int W_S = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  int                 sel;
  logic               start;
  logic               vec_valid;
  logic               res_ready;
  logic [DIM*W_u-1:0] vec_data;

  logic [DIM*W_u-1:0] sum_u_a, sum_u_b;
  logic [W_S-1:0]     sum_in_a, sum_in_b;
  logic [W_S-1:0]     dp_a [LAT];
  logic [W_S-1:0]     dp_b [LAT];
  logic               busy_a, busy_b, done_a, done_b;

  vector_sum_sequencer_if #(.DIM(DIM), .W_u(W_u), .W_S(W_S), .W_R(2)) if_a ();
  vector_sum_sequencer_if #(.DIM(DIM), .W_u(W_u), .W_S(W_S), .W_R(3)) if_b ();

  assign if_a.vec_valid = vec_valid && (sel == 0);
  assign if_a.vec_data  = vec_data;
  assign if_a.res_ready = res_ready && (sel == 0);
  assign if_b.vec_valid = vec_valid && (sel == 1);
  assign if_b.vec_data  = vec_data;
  assign if_b.res_ready = res_ready && (sel == 1);

  vector_sum_sequencer #(.DIM(DIM), .W_u(W_u), .ROWS(4), .LAT(LAT)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start && (sel == 0)),
    .o_busy(busy_a), .o_done(done_a), .o_sum_u(sum_u_a), .i_sum_in(sum_in_a),
    .s_if(if_a.slave));

  vector_sum_sequencer #(.DIM(DIM), .W_u(W_u), .ROWS(8), .LAT(LAT)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start && (sel == 1)),
    .o_busy(busy_b), .o_done(done_b), .o_sum_u(sum_u_b), .i_sum_in(sum_in_b),
    .s_if(if_b.slave));

  // External vectorSum datapath stand-in: LAT-cycle pipelined adder tree.
  function automatic logic [W_S-1:0] dp_sum(input logic [DIM*W_u-1:0] u);
    logic [W_S-1:0] acc;
    acc = '0;
    for (int i = 0; i < DIM; i++) acc = acc + W_S'(u[i*W_u +: W_u]);
    return acc;
  endfunction

  always @(posedge clk) begin
    dp_a[0] <= dp_sum(sum_u_a);
    dp_b[0] <= dp_sum(sum_u_b);
    for (int k = 1; k < LAT; k++) begin
      dp_a[k] <= dp_a[k-1];
      dp_b[k] <= dp_b[k-1];
    end
  end
  assign sum_in_a = dp_a[LAT-1];
  assign sum_in_b = dp_b[LAT-1];

  logic           m_vr, m_rv, m_busy, m_done, m_last;
  logic [W_S-1:0] m_data;
  logic [2:0]     m_row;
  logic [DIM*W_u-1:0] m_sum_u;

  always_comb begin
    if (sel == 0) begin
      m_vr = if_a.vec_ready; m_rv = if_a.res_valid; m_busy = busy_a; m_done = done_a;
      m_last = if_a.res_last; m_data = if_a.res_data; m_row = {1'b0, if_a.res_row};
      m_sum_u = sum_u_a;
    end else begin
      m_vr = if_b.vec_ready; m_rv = if_b.res_valid; m_busy = busy_b; m_done = done_b;
      m_last = if_b.res_last; m_data = if_b.res_data; m_row = if_b.res_row;
      m_sum_u = sum_u_b;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one entry per accepted vector, in acceptance order.
  typedef struct { longint sum; int row; bit last; } res_t;
  res_t exp_q[$];

  typedef struct {
    int s; int vm; int rm; int dm; bit inj; int exp_lat; int exp_hold;
  } job_t;

  task automatic run_job(input job_t j);
    int nrows, issued, popped, done_cnt, k;
    int first_acc, first_rv, last_pop, done_cyc, hold_acc;
    bit pending, busy_at_done, vr_at_hold;
    longint cur_sum;
    logic [31:0] e;
    res_t r;
    nrows = (j.s != 0) ? 8 : 4;
    issued = 0; popped = 0; done_cnt = 0; k = 0;
    first_acc = -1; first_rv = -1; last_pop = -1; done_cyc = -1; hold_acc = -1;
    pending = 0; busy_at_done = 1; vr_at_hold = 1; cur_sum = 0;
    sel = j.s;
    @(negedge clk);
    start = 1'b1; vec_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (k < 600) begin
      if (!pending && issued < nrows && (j.vm == 0 || (k % 3) == 0)) begin
        cur_sum = 0;
        for (int i = 0; i < DIM; i++) begin
          e = (j.dm == 0) ? 32'(issued + 1) : (j.dm == 2) ? 32'hFFFF_FFFF : $urandom;
          vec_data[i*W_u +: W_u] = e;
          cur_sum += longint'(e);
        end
        pending = 1;
      end
      vec_valid = pending;
      case (j.rm)
        0:       res_ready = 1'b1;
        1:       res_ready = ($urandom_range(0, 1) == 1);
        default: res_ready = (k >= 30);
      endcase
      start = j.inj && (k == 3);
      #1;
      if (k == 0) check("busy_in_run", m_busy, 1);
      if (m_rv && first_rv < 0) first_rv = k;
      if (m_rv && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("res_data", longint'(m_data), r.sum);
          check("res_row", longint'(m_row), r.row);
          check("res_last", longint'(m_last), r.last);
          if (j.dm == 0) check("res_data_const", longint'(m_data), 10 * (r.row + 1));
          if (j.dm == 2) check("res_data_all_ones", longint'(m_data), 64'd42949672950);
        end
        popped++;
        last_pop = k;
      end
      if (vec_valid && m_vr) begin
        r.sum = cur_sum; r.row = issued; r.last = (issued == nrows - 1);
        exp_q.push_back(r);
        if (first_acc < 0) first_acc = k;
        issued++;
        pending = 0;
      end
      if (m_done) begin
        done_cnt++;
        done_cyc = k;
        busy_at_done = m_busy;
      end
      if (j.rm == 2 && k == 29) begin
        hold_acc = issued;
        vr_at_hold = m_vr;
      end
      if (done_cnt > 0 && k >= done_cyc + 4) break;
      k++;
      @(negedge clk);
    end
    vec_valid = 1'b0; res_ready = 1'b0; start = 1'b0;
    check("job_finished", (done_cnt > 0) ? 1 : 0, 1);
    check("done_pulses", done_cnt, 1);
    check("results_popped", popped, nrows);
    check("model_drained", exp_q.size(), 0);
    check("done_after_last_pop", done_cyc, last_pop + 1);
    check("busy_low_at_done", busy_at_done, 0);
    if (j.exp_lat >= 0) begin
      check("first_accept_cycle", first_acc, 0);
      check("first_result_latency", first_rv - first_acc, j.exp_lat);
    end
    if (j.exp_hold >= 0) begin
      check("accepted_while_held", hold_acc, j.exp_hold);
      check("ready_low_while_held", vr_at_hold, 0);
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic reset_mid_job();
    int issued, k;
    issued = 0; k = 0;
    sel = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vec_valid = 1'b1; res_ready = 1'b1;
    while (k < 20 && issued < 2) begin
      vec_data = {DIM{32'(k + 7)}};
      #1;
      if (m_vr) issued++;
      k++;
      @(negedge clk);
    end
    check("issued_before_reset", issued, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_res_valid", m_rv, 0);
    check("rst_mid_busy", m_busy, 0);
    check("rst_mid_vec_ready", m_vr, 0);
    check("rst_mid_done", m_done, 0);
    vec_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
  endtask

  job_t jobs[6];

  initial begin
    jobs[0] = '{s: 0, vm: 0, rm: 0, dm: 0, inj: 1'b0, exp_lat: 6,  exp_hold: -1};
    jobs[1] = '{s: 1, vm: 0, rm: 2, dm: 1, inj: 1'b0, exp_lat: -1, exp_hold: 6};
    jobs[2] = '{s: 0, vm: 1, rm: 1, dm: 1, inj: 1'b0, exp_lat: -1, exp_hold: -1};
    jobs[3] = '{s: 1, vm: 1, rm: 1, dm: 1, inj: 1'b0, exp_lat: -1, exp_hold: -1};
    jobs[4] = '{s: 0, vm: 0, rm: 1, dm: 1, inj: 1'b1, exp_lat: -1, exp_hold: -1};
    jobs[5] = '{s: 0, vm: 0, rm: 0, dm: 2, inj: 1'b0, exp_lat: 6,  exp_hold: -1};

    rst = 1'b1; sel = 0; start = 1'b0; vec_valid = 1'b1; res_ready = 1'b0;
    vec_data = {DIM{32'h5}};
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_vec_ready", m_vr, 0);
    check("rst_res_valid", m_rv, 0);
    check("rst_res_data", longint'(m_data), 0);
    check("rst_res_row", longint'(m_row), 0);
    check("rst_res_last", m_last, 0);
    check("rst_sum_u_zero", (m_sum_u == '0) ? 1 : 0, 1);
    check("rst_b_busy", busy_b, 0);
    rst = 1'b0; vec_valid = 1'b0;
    @(negedge clk);
    #1;
    check("idle_ignores_valid_ready", m_vr, 0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    reset_mid_job();
    run_job(jobs[2]);
    run_job(jobs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_sum_sequencer.md
# vector_sum_sequencer

Sequencer that shares one pipelined `vectorSum` datapath among the rows of a job. Accepts a job of ROWS vectors over a valid/ready stream and issues one vector per cycle into the datapath. Tracks each in-flight row with a tag pipeline that matches the datapath latency, and buffers scalar results in a credit-managed FIFO so downstream backpressure never stalls the non-stallable datapath. Sits between the matrix operand fetch and the result write-back in the matrix multiply engine.

## Interface
- DIM, 10, elements per vector (passed to the datapath)
- W_u, 32, element bit-width
- ROWS, 4, vectors per job (≥1)
- LAT, 4, datapath latency in cycles from `sum_u` presented to `sum_in` valid (≥1)
- DEPTH, LAT+2, result FIFO entries (≥LAT+1)
- W_S (derived), W_u+CLOG2(DIM), result width
- W_R (derived), max(1,CLOG2(ROWS)), row tag width

Ports:
- Clock  in  1  single clock, all state on posedge
- Reset  in  1  synchronous, active-high
- start  in  1  begin a job; honoured only in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the job's last result has been handed off
- vec_valid  in  1  input vector valid
- vec_ready  out  1  sequencer accepts vector this cycle
- vec_data  in  DIM*W_u  input vector
- sum_u  out  DIM*W_u  registered vector to datapath `u`
- sum_in  in  W_S  datapath `sum`
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  W_S  scalar sum
- res_row  out  W_R  row index of result (0..ROWS-1)
- res_last  out  1  result is row ROWS-1

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start. Clear issue count, retire count, and tag pipeline.
  - RUN→DRAIN on the handshake that issues row ROWS-1.
  - DRAIN→DONE on the res handshake of row ROWS-1.
  - DONE→IDLE unconditionally. `done`=1 only in DONE.
- vec_ready = (state==RUN) && credit. credit = (inflight + fifo_count) < DEPTH. inflight = popcount of the valid pipeline.
- Issue on vec_valid&&vec_ready:
  - register vec_data into sum_u;
  - shift valid=1 and tag=issue_count into a LAT-stage pipeline;
  - issue_count++.
- No issue: shift valid=0 into the pipeline. sum_u holds its last value.
- When the pipeline output valid=1, push {sum_in, tag, tag==ROWS-1} into the FIFO. Credit guarantees the FIFO is never full at push. A push to a full FIFO is a design error; flag it with an assertion.
- FIFO pop on res_valid&&res_ready. res_* show the FIFO head; res_valid = !empty.
- Simultaneous push and pop on the same cycle is legal, including when the FIFO holds one entry or DEPTH entries.
- start while busy is ignored. vec_valid outside RUN is ignored (vec_ready=0).
- Reset mid-job discards all in-flight and buffered results. No done pulse is generated.
- Arithmetic: no truncation. Widths are exact per W_S/W_R. Counters are W_R+1 bits and never wrap within a job.

## Timing
- Reset values:
  - state=IDLE; busy=0; done=0; vec_ready=0; res_valid=0.
  - res_data=0; res_row=0; res_last=0; sum_u=0.
  - Valid pipeline all 0; FIFO empty.
- start sampled in cycle 0 → RUN in cycle 1; vec_ready can be 1 in cycle 1.
- Vector accepted in cycle t → sum_u valid in cycle t+1 → sum_in captured at end of cycle t+1+LAT → res_valid earliest in cycle t+2+LAT.
- Sustained throughput is one row per cycle while res_ready=1.
- res_ready=0: at most DEPTH rows outstanding. Then vec_ready=0 until a pop frees credit, effective the cycle after the pop.
- done asserts the cycle after the final res handshake. busy drops in that same cycle.

## Structure
- Package `vector_sum_pkg`:
  - FSM state enum;
  - CLOG2 macro/function;
  - W_S/W_R derivation constants.
- Sub-module `sync_fifo` (parameters width and DEPTH, synchronous reset; outputs count, empty, full) for result buffering.
- Tag/valid pipeline is inline shift registers.
- The `vectorSum` datapath is instantiated by the parent, not inside this block.

## Test plan
- ROWS=4, LAT=4, res_ready=1, vec_valid continuous with row r elements = r+1 (DIM=10) → sums 10,20,30,40. res_row 0..3, res_last only on row 3. First res_valid 6 cycles after first accept; done 1 cycle after 4th pop.
- res_ready=0 entire job, DEPTH=6, ROWS=8 → exactly 6 vectors accepted, then vec_ready=0. Release res_ready → remaining 2 accepted, all 8 results in order, no loss.
- Gapped vec_valid (1 of every 3 cycles) with random res_ready → results match the reference sum per row, in row order.
- start pulsed during RUN → ignored: issue count and row tags unchanged, single done per job.
- Reset asserted 2 cycles after 2nd issue → next cycle: res_valid=0, busy=0, vec_ready=0. New job after reset produces rows from 0 with no stale results.
- All-ones elements, W_u=32, DIM=10 → sum = 10×(2^32−1), fits W_S=36 bits without overflow.
